// File: rtl/wave_sweep_sequencer.sv
// Frequency-sweep / burst sequencer for one waveform-generator channel.
// Drives freq_out and ch_en through dwell-timed linear up or up/down ramps.
module wave_sweep_sequencer #(
  parameter int FREQ_W  = 32,
  parameter int DWELL_W = 32,
  parameter int PASS_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              bidir,
  input  logic [FREQ_W-1:0] freq_start,
  input  logic [FREQ_W-1:0] freq_stop,
  input  logic [FREQ_W-1:0] freq_step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [PASS_W-1:0] passes,
  output logic [FREQ_W-1:0] freq_out,
  output logic              ch_en,
  output logic              busy,
  output logic              step_strobe,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_UP,
    S_DOWN,
    S_FINISH
  } state_t;

  state_t              state, state_nxt;
  logic [FREQ_W-1:0]   freq_nxt;
  logic                ch_en_nxt, busy_nxt, strobe_nxt, done_nxt, err_nxt;
  logic [DWELL_W-1:0]  dwell_cnt, dwell_nxt;
  logic [PASS_W-1:0]   pass_cnt, pass_nxt, pass_inc;
  logic                latch, pass_end, expire, pass_hit;

  logic [FREQ_W-1:0]   cfg_start, cfg_stop, cfg_step;
  logic [DWELL_W-1:0]  cfg_reload;
  logic [PASS_W-1:0]   cfg_passes;
  logic                cfg_bidir;

  // Sums/differences are formed one bit wider so the ramp clamps instead of wrapping.
  function automatic logic [FREQ_W-1:0] sat_add(input logic [FREQ_W-1:0] f,
                                                 input logic [FREQ_W-1:0] inc,
                                                 input logic [FREQ_W-1:0] lim);
    logic [FREQ_W:0] sum;
    sum = {1'b0, f} + {1'b0, inc};
    if (sum >= {1'b0, lim}) sat_add = lim;
    else                    sat_add = sum[FREQ_W-1:0];
  endfunction

  function automatic logic [FREQ_W-1:0] sat_sub(input logic [FREQ_W-1:0] f,
                                                 input logic [FREQ_W-1:0] dec,
                                                 input logic [FREQ_W-1:0] lim);
    logic [FREQ_W:0] diff;
    diff = {1'b0, f} - {1'b0, dec};
    if (diff[FREQ_W] || (diff[FREQ_W-1:0] <= lim)) sat_sub = lim;
    else                                           sat_sub = diff[FREQ_W-1:0];
  endfunction

  // Counter reload value: a dwell of 0 behaves as 1.
  function automatic logic [DWELL_W-1:0] dwell_reload(input logic [DWELL_W-1:0] d);
    if (d == '0) dwell_reload = '0;
    else         dwell_reload = d - DWELL_W'(1);
  endfunction

  assign expire   = (dwell_cnt == '0);
  assign pass_inc = (&pass_cnt) ? pass_cnt : pass_cnt + PASS_W'(1);
  assign pass_hit = (cfg_passes != '0) && (pass_inc == cfg_passes);

  always_comb begin
    state_nxt  = state;
    freq_nxt   = freq_out;
    ch_en_nxt  = ch_en;
    strobe_nxt = 1'b0;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    dwell_nxt  = dwell_cnt;
    pass_nxt   = pass_cnt;
    latch      = 1'b0;
    pass_end   = 1'b0;

    case (state)
      S_IDLE: begin
        ch_en_nxt = 1'b0;
        if (start && !abort) begin
          if ((freq_step == '0) || (freq_stop < freq_start)) begin
            err_nxt = 1'b1;
          end else begin
            latch     = 1'b1;
            freq_nxt  = freq_start;
            pass_nxt  = '0;
            state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        state_nxt = S_UP;
        ch_en_nxt = 1'b1;
        dwell_nxt = cfg_reload;
      end
      S_UP: begin
        if (expire) begin
          dwell_nxt = cfg_reload;
          if (freq_out == cfg_stop) begin
            if (cfg_bidir && (cfg_stop != cfg_start)) state_nxt = S_DOWN;
            else                                      pass_end  = 1'b1;
          end else begin
            freq_nxt   = sat_add(freq_out, cfg_step, cfg_stop);
            strobe_nxt = 1'b1;
          end
        end else begin
          dwell_nxt = dwell_cnt - DWELL_W'(1);
        end
      end
      S_DOWN: begin
        if (expire) begin
          dwell_nxt = cfg_reload;
          if (freq_out == cfg_start) begin
            pass_end = 1'b1;
          end else begin
            freq_nxt   = sat_sub(freq_out, cfg_step, cfg_start);
            strobe_nxt = 1'b1;
          end
        end else begin
          dwell_nxt = dwell_cnt - DWELL_W'(1);
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
        ch_en_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        ch_en_nxt = 1'b0;
      end
    endcase

    // A repeated pass re-enters UP directly so the channel phase stays continuous.
    if (pass_end) begin
      pass_nxt = pass_inc;
      if (pass_hit) begin
        state_nxt = S_FINISH;
        ch_en_nxt = 1'b0;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = S_UP;
        if (freq_out != cfg_start) begin
          freq_nxt   = cfg_start;
          strobe_nxt = 1'b1;
        end
      end
    end

    if (abort && (state != S_IDLE)) begin
      state_nxt  = S_IDLE;
      ch_en_nxt  = 1'b0;
      freq_nxt   = freq_out;
      strobe_nxt = 1'b0;
      done_nxt   = 1'b0;
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      freq_out    <= '0;
      ch_en       <= 1'b0;
      busy        <= 1'b0;
      step_strobe <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
      dwell_cnt   <= '0;
      pass_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      freq_out    <= freq_nxt;
      ch_en       <= ch_en_nxt;
      busy        <= busy_nxt;
      step_strobe <= strobe_nxt;
      done        <= done_nxt;
      cfg_err     <= err_nxt;
      dwell_cnt   <= dwell_nxt;
      pass_cnt    <= pass_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (latch) begin
      cfg_start  <= freq_start;
      cfg_stop   <= freq_stop;
      cfg_step   <= freq_step;
      cfg_reload <= dwell_reload(dwell);
      cfg_passes <= passes;
      cfg_bidir  <= bidir;
    end
  end

endmodule
